// File: rtl/branch_predictor_unit_pkg.sv
// Shared types for the fetch-tag branch predictor: control-flow classes,
// BTB entry layout and the prediction bundle.
package branch_predictor_unit_pkg;

  typedef enum logic [1:0] {
    CF_COND   = 2'd0,
    CF_JUMP   = 2'd1,
    CF_CALL   = 2'd2,
    CF_RETURN = 2'd3
  } cf_type_t;

  localparam int DEF_NUM_ENTRIES = 1024;
  localparam int DEF_CTR_BITS    = 2;
  localparam int DEF_IDX_BITS    = $clog2(DEF_NUM_ENTRIES);
  localparam int DEF_TAG_BITS    = 30 - DEF_IDX_BITS;

  typedef struct packed {
    logic [DEF_TAG_BITS-1:0] tag;
    logic [29:0]             target;
    cf_type_t                cf_type;
    logic [DEF_CTR_BITS-1:0] ctr;
  } btb_entry_t;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } bp_pred_t;

  // Word address back to a byte address (low two bits always zero).
  function automatic logic [31:0] word_to_addr(input logic [29:0] w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/bram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module bram_1r1w #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read; non-blocking write keeps read-before-write order.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/branch_predictor_unit_ras.sv
// Return address stack: circular buffer, oldest entry overwritten on overflow,
// pop on empty is ignored.
module return_address_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 30,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = PTR_BITS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [WIDTH-1:0]    push_data,
  output logic [WIDTH-1:0]    top,
  output logic [CNT_BITS-1:0] count
);

  logic [WIDTH-1:0]    stack [DEPTH];
  logic [PTR_BITS-1:0] ptr;

  // Pointer/count bookkeeping; ptr addresses the next free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != CNT_BITS'(DEPTH)) count <= count + 1'b1;
    end else if (pop && count != '0) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  // Stack payload; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (push && !flush) stack[ptr] <= push_data;
  end

  assign top = stack[ptr - 1'b1];

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB with saturating direction counters, control-flow typing
// and a return address stack. Lookup latency is one cycle; training arrives
// from writeback in program order.
module branch_predictor_unit
  import branch_predictor_unit_pkg::*;
#(
  parameter int NUM_ENTRIES = 1024,
  parameter int CTR_BITS    = 2,
  parameter int RAS_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  cf_type_t    upd_type
);

  localparam int IDX_BITS = $clog2(NUM_ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;
  localparam int RAS_CNT  = $clog2(RAS_DEPTH) + 1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  assign lk_idx = lookup_pc[IDX_BITS+1:2];
  assign lk_tag = lookup_pc[31:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[31:IDX_BITS+2];

  logic unused_bits;
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Valid, tag and counter live in flops so an update can resolve hit/miss
  // and read-modify-write the counter in the same cycle.
  logic [NUM_ENTRIES-1:0] valid_arr;
  logic [TAG_BITS-1:0]    tag_arr [NUM_ENTRIES];
  logic [CTR_BITS-1:0]    ctr_arr [NUM_ENTRIES];

  logic                upd_go, up_hit, ctr_we, pay_we;
  logic [CTR_BITS-1:0] ctr_cur, ctr_new;
  assign upd_go  = upd_valid && !flush;
  assign up_hit  = valid_arr[up_idx] && (tag_arr[up_idx] == up_tag);
  assign ctr_cur = ctr_arr[up_idx];
  assign pay_we  = upd_go && upd_taken;

  // Next counter value for the entry being trained.
  always_comb begin
    ctr_we  = 1'b0;
    ctr_new = ctr_cur;
    if (upd_type != CF_COND) begin
      if (up_hit || upd_taken) begin
        ctr_we  = 1'b1;
        ctr_new = '1;
      end
    end else if (up_hit) begin
      ctr_we = 1'b1;
      if (upd_taken && ctr_cur != '1)       ctr_new = ctr_cur + 1'b1;
      else if (!upd_taken && ctr_cur != '0) ctr_new = ctr_cur - 1'b1;
    end else if (upd_taken) begin
      ctr_we  = 1'b1;
      ctr_new = CTR_WEAK;
    end
  end

  // Valid bits: cleared by reset or flush, set on allocation/taken update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        valid_arr <= '0;
    else if (flush)  valid_arr <= '0;
    else if (pay_we) valid_arr[up_idx] <= 1'b1;
  end

  // Tag and counter arrays; payload is don't-care until valid is set.
  always_ff @(posedge clk) begin
    if (pay_we)           tag_arr[up_idx] <= up_tag;
    if (upd_go && ctr_we) ctr_arr[up_idx] <= ctr_new;
  end

  // Target and type payload in block RAM: {target[31:2], type}.
  logic [31:0] rd_payload;
  bram_1r1w #(.DEPTH(NUM_ENTRIES), .WIDTH(32)) u_btb_ram (
    .clk   (clk),
    .we    (pay_we),
    .waddr (up_idx),
    .wdata ({upd_target[31:2], upd_type}),
    .re    (lookup_en),
    .raddr (lk_idx),
    .rdata (rd_payload)
  );

  logic [29:0]        ras_top;
  logic [RAS_CNT-1:0] ras_count;
  return_address_stack #(.DEPTH(RAS_DEPTH), .WIDTH(30)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (upd_go && upd_type == CF_CALL),
    .pop       (upd_go && upd_type == CF_RETURN),
    .push_data (upd_pc[31:2] + 30'd1),
    .top       (ras_top),
    .count     (ras_count)
  );

  // Lookup-side state captured in cycle N alongside the RAM read; a lookup
  // during flush is forced to miss.
  logic        lk_q, hit_q, msb_q, ras_ne_q;
  logic [29:0] ras_top_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_q      <= 1'b0;
      hit_q     <= 1'b0;
      msb_q     <= 1'b0;
      ras_ne_q  <= 1'b0;
      ras_top_q <= '0;
    end else begin
      lk_q      <= lookup_en;
      hit_q     <= lookup_en && !flush && valid_arr[lk_idx] && (tag_arr[lk_idx] == lk_tag);
      msb_q     <= ctr_arr[lk_idx][CTR_BITS-1];
      ras_ne_q  <= (ras_count != '0);
      ras_top_q <= ras_top;
    end
  end

  cf_type_t rd_type;
  bp_pred_t pred;
  assign rd_type = cf_type_t'(rd_payload[1:0]);

  // Form the prediction in cycle N+1 from the captured state.
  always_comb begin
    pred       = '0;
    pred.valid = lk_q;
    pred.taken = lk_q && hit_q && (rd_type != CF_COND || msb_q)
                 && !(rd_type == CF_RETURN && !ras_ne_q);
    if (pred.taken)
      pred.target = (rd_type == CF_RETURN) ? word_to_addr(ras_top_q)
                                           : word_to_addr(rd_payload[31:2]);
  end

  assign pred_valid  = pred.valid;
  assign pred_taken  = pred.taken;
  assign pred_target = pred.target;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed-vector bench for branch_predictor_unit with hand-computed results.
module tb_branch_predictor_unit;
  import branch_predictor_unit_pkg::*;

  localparam int NE = 1024;
  localparam int RD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        lookup_en = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  cf_type_t    upd_type = CF_COND;

  int checks = 0;
  int errors = 0;

  branch_predictor_unit #(.NUM_ENTRIES(NE), .CTR_BITS(2), .RAS_DEPTH(RD)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .lookup_en   (lookup_en),
    .lookup_pc   (lookup_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_type    (upd_type)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_pred(input string tag, input logic v, input logic t, input logic [31:0] tgt);
    $display("pred %s valid=%0d taken=%0d target=%h", tag, pred_valid, pred_taken, pred_target);
    chk({tag, ".valid"},  {31'd0, pred_valid}, {31'd0, v});
    chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, t});
    chk({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input cf_type_t ty);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = t;
    upd_target = tgt;
    upd_type   = ty;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input cf_type_t ty);
    set_upd(pc, t, tgt, ty);
    step();
    upd_valid = 1'b0;
    $display("update pc=%h taken=%0d target=%h type=%0d", pc, t, tgt, ty);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    lookup_en = 1'b1;
    lookup_pc = pc;
    step();
    lookup_en = 1'b0;
    check_pred(tag, 1'b1, t, tgt);
  endtask

  initial begin
    logic [31:0] cpc;
    repeat (2) @(negedge clk);
    check_pred("reset", 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    step();

    // Cold lookup misses
    look("cold", 32'h100, 1'b0, 32'h0);

    // Allocation with weakly-taken counter
    upd(32'h100, 1'b1, 32'h200, CF_COND);
    look("alloc", 32'h100, 1'b1, 32'h200);
    step();
    check_pred("idle", 1'b0, 1'b0, 32'h0);

    // Counter down to 0 and clamp there
    upd(32'h100, 1'b0, 32'h0, CF_COND);
    look("ctr01", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0, CF_COND);
    upd(32'h100, 1'b0, 32'h0, CF_COND);
    upd(32'h100, 1'b1, 32'h200, CF_COND);
    look("clamp0", 32'h100, 1'b0, 32'h0);

    // Counter up to 3 and clamp there
    upd(32'h100, 1'b1, 32'h200, CF_COND);
    upd(32'h100, 1'b1, 32'h200, CF_COND);
    upd(32'h100, 1'b1, 32'h200, CF_COND);
    look("sat3", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, CF_COND);
    look("sat3_dn", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, CF_COND);
    look("ctr01b", 32'h100, 1'b0, 32'h0);

    // Alias at the same index with a different tag
    look("alias", 32'h100 + 4 * NE, 1'b0, 32'h0);

    // Same-cycle lookup and update: old state first, new state next
    set_upd(32'h100, 1'b1, 32'h240, CF_COND);
    lookup_en = 1'b1; lookup_pc = 32'h100;
    step();
    upd_valid = 1'b0; lookup_en = 1'b0;
    check_pred("same1_old", 1'b1, 1'b0, 32'h0);
    look("same1_new", 32'h100, 1'b1, 32'h240);
    set_upd(32'h100, 1'b1, 32'h280, CF_COND);
    lookup_en = 1'b1; lookup_pc = 32'h100;
    step();
    upd_valid = 1'b0; lookup_en = 1'b0;
    check_pred("same2_old", 1'b1, 1'b1, 32'h240);
    look("same2_new", 32'h100, 1'b1, 32'h280);

    // Return entry with empty RAS, then a call fills it
    upd(32'h840, 1'b1, 32'h304, CF_RETURN);
    look("ret_empty", 32'h840, 1'b0, 32'h0);
    upd(32'h300, 1'b1, 32'h800, CF_CALL);
    look("call_tgt", 32'h300, 1'b1, 32'h800);
    look("ret_top", 32'h840, 1'b1, 32'h304);
    upd(32'h840, 1'b1, 32'h304, CF_RETURN);

    // RAS_DEPTH+1 calls then RAS_DEPTH+1 returns
    for (int k = 0; k <= RD; k++) upd(32'h3000 + 32'(16 * k), 1'b1, 32'h800, CF_CALL);
    for (int j = 0; j <= RD; j++) begin
      cpc = 32'h3000 + 32'(16 * (RD - j)) + 32'd4;
      if (j < RD) look($sformatf("ras_pop%0d", j), 32'h840, 1'b1, cpc);
      else        look("ras_empty", 32'h840, 1'b0, 32'h0);
      upd(32'h840, 1'b1, 32'h304, CF_RETURN);
    end

    // Flush together with an update and a lookup
    upd(32'h300, 1'b1, 32'h800, CF_CALL);
    upd(32'h300, 1'b1, 32'h800, CF_CALL);
    flush = 1'b1;
    set_upd(32'h500, 1'b1, 32'h900, CF_CALL);
    lookup_en = 1'b1; lookup_pc = 32'h100;
    step();
    flush = 1'b0; upd_valid = 1'b0; lookup_en = 1'b0;
    check_pred("flush_cyc", 1'b1, 1'b0, 32'h0);
    look("fl_100", 32'h100, 1'b0, 32'h0);
    look("fl_300", 32'h300, 1'b0, 32'h0);
    look("fl_500", 32'h500, 1'b0, 32'h0);
    upd(32'h840, 1'b1, 32'h304, CF_RETURN);
    look("fl_ras", 32'h840, 1'b0, 32'h0);

    // Reset asserted while a lookup is in flight
    upd(32'h100, 1'b1, 32'h200, CF_COND);
    look("pre_rst", 32'h100, 1'b1, 32'h200);
    lookup_en = 1'b1; lookup_pc = 32'h100;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    lookup_en = 1'b0;
    check_pred("rst_mid", 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    step();
    look("post_rst", 32'h100, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
